// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the MDU op-code constants, the sequencer state type,
// the iteration-engine mode type and the default operand width.
package mdu_ctrl_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  // ITER defaults to the operand width, so this also sets the iteration count.
  localparam int unsigned MDU_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

  typedef enum logic {
    ITER_MUL = 1'b0,
    ITER_DIV = 1'b1
  } iter_mode_t;

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU handshake and result bundle.
//   start/MDUctr/A/B/flush : request from the pipeline (master drives)
//   busy/done/HI/LO        : status and architectural HI/LO (slave drives)
interface mdu_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       MDUctr;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, MDUctr, A, B, flush,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, MDUctr, A, B, flush,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/mdu_iter.sv
// Iteration engine: 2*WIDTH product/remainder register plus the
// adder/subtractor, one radix-2 step per enabled cycle.
//   clk, rst  : clock, synchronous active-low reset
//   load      : capture acc_init into the low half (high half cleared) and m_init
//   step      : perform one iteration in the selected mode
//   mode      : ITER_MUL shift-add, ITER_DIV restoring shift-subtract
//   acc       : {HI-part, LO-part}; product, or {remainder, quotient}
module mdu_iter
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  iter_mode_t         mode,
  input  logic [WIDTH-1:0]   acc_init,
  input  logic [WIDTH-1:0]   m_init,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set; the carry becomes the new MSB after shift.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    // Divide: shift the next dividend bit into the partial remainder,
    // kept one bit wider so the trial subtraction cannot overflow.
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, m};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      m   <= '0;
    end else if (load) begin
      acc <= {{WIDTH{1'b0}}, acc_init};
      m   <= m_init;
    end else if (step) begin
      if (mode == ITER_MUL) begin
        acc <= {mul_sum, acc[WIDTH-1:1]};
      end else if (rem_diff[WIDTH]) begin
        acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc <= {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit with HI/LO registers.
// Sequences MULT/MULTU/DIV/DIVU through mdu_iter on unsigned magnitudes,
// applies sign correction in FIX, and services MTHI/MTLO directly in IDLE.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave side of mdu_ctrl_if (start, MDUctr, A, B, flush in;
//              busy, done, HI, LO out)
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH_DEFAULT,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  mdu_ctrl_if.slave  bus
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  mdu_state_t         state;
  logic [CW-1:0]      counter;
  logic               neg;
  logic               rem_neg;
  logic               suppress;
  logic               is_div;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  logic               op_signed;
  logic               op_mul;
  logic               op_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               load;
  logic               step;
  iter_mode_t         mode;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    op_signed = (bus.MDUctr == MDU_MULT) || (bus.MDUctr == MDU_DIV);
    op_mul    = (bus.MDUctr == MDU_MULT) || (bus.MDUctr == MDU_MULTU);
    op_div    = (bus.MDUctr == MDU_DIV)  || (bus.MDUctr == MDU_DIVU);
    a_mag     = (op_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag     = (op_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    load      = (state == IDLE) && bus.start && !bus.flush &&
                (op_mul || (op_div && (bus.B != '0)));
    step      = (state == MUL) || (state == DIV);
    mode      = (state == DIV) ? ITER_DIV : ITER_MUL;
    prod_fix  = neg ? -acc : acc;
    quo_fix   = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Multiplier goes into the shifting half for MUL; dividend for DIV.
  mdu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .mode     (mode),
    .acc_init (op_mul ? b_mag : a_mag),
    .m_init   (op_mul ? a_mag : b_mag),
    .acc      (acc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      counter  <= '0;
      neg      <= 1'b0;
      rem_neg  <= 1'b0;
      suppress <= 1'b0;
      is_div   <= 1'b0;
      done_reg <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            counter  <= '0;
            neg      <= op_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            rem_neg  <= op_signed && bus.A[WIDTH-1];
            suppress <= 1'b0;
            case (bus.MDUctr)
              MDU_MTHI: begin
                hi_reg   <= bus.A;
                done_reg <= 1'b1;
              end
              MDU_MTLO: begin
                lo_reg   <= bus.A;
                done_reg <= 1'b1;
              end
              MDU_MULT, MDU_MULTU: begin
                is_div <= 1'b0;
                state  <= MUL;
              end
              MDU_DIV, MDU_DIVU: begin
                is_div <= 1'b1;
                if (bus.B == '0) begin
                  suppress <= 1'b1;
                  state    <= FIX;
                end else begin
                  state    <= DIV;
                end
              end
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (bus.flush) begin
            state <= IDLE;
          end else if (counter == CW'(ITER - 1)) begin
            state <= FIX;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!bus.flush) begin
            done_reg <= 1'b1;
            if (!suppress) begin
              if (is_div) begin
                hi_reg <= rem_fix;
                lo_reg <= quo_fix;
              end else begin
                {hi_reg, lo_reg} <= prod_fix;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_reg;
  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mdu_ctrl_if #(.WIDTH(32)) bus ();

  mdu_ctrl #(.WIDTH(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an op, straight from integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (op)
      MDU_MULT:  res = sa * sb;
      MDU_MULTU: res = {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        q   = sa / sb;
        r   = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      MDU_DIVU:  res = {a % b, a / b};
      default: ;
    endcase
    return res;
  endfunction

  // Transaction-level model: an accepted MUL/DIV keeps the unit busy for a
  // fixed number of cycles, then the pending result lands with a done pulse.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0, p_write = 1'b0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (bus.flush) begin
          m_left = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1'b1;
            if (p_write) {m_hi, m_lo} = {p_hi, p_lo};
          end
        end
      end else if (bus.start && !bus.flush) begin
        case (bus.MDUctr)
          MDU_MTHI: begin m_hi = bus.A; m_done = 1'b1; end
          MDU_MTLO: begin m_lo = bus.A; m_done = 1'b1; end
          MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
            p_write = !(bus.MDUctr[1] && bus.B == 32'd0);
            if (p_write) {p_hi, p_lo} = ref_result(bus.MDUctr, bus.A, bus.B);
            m_left  = p_write ? 33 : 1;
          end
          default: ;
        endcase
      end
    end
    #1;
    check("busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
    check("done", {31'd0, bus.done}, {31'd0, m_done});
    check("HI", bus.HI, m_hi);
    check("LO", bus.LO, m_lo);
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    @(negedge clk);
    bus.start = 1'b1; bus.MDUctr = op; bus.A = a; bus.B = b; bus.flush = fl;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.MDUctr = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout actual=%0d required=<100", n);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    drive(op, a, b, 1'b0);
    wait_idle(n);
    check({name, "_busy_cycles"}, n, exp_busy);
    check({name, "_done"}, {31'd0, bus.done}, 32'd1);
    check({name, "_HI"}, bus.HI, exp_hi);
    check({name, "_LO"}, bus.LO, exp_lo);
  endtask

  initial begin
    logic [63:0] r;
    int n;
    logic [2:0]  op;
    logic [31:0] a, b;

    bus.start = 1'b0; bus.MDUctr = '0; bus.A = '0; bus.B = '0; bus.flush = 1'b0;

    // Pin the reference arithmetic against hand-computed values.
    r = ref_result(MDU_MULT, 32'hFFFFFFFD, 32'd5);
    check("model_mult", r[63:32], 32'hFFFFFFFF); check("model_mult_lo", r[31:0], 32'hFFFFFFF1);
    r = ref_result(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("model_multu", r[63:32], 32'hFFFFFFFE); check("model_multu_lo", r[31:0], 32'h1);
    r = ref_result(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    check("model_div_ovf", r[63:32], 32'h0); check("model_div_ovf_lo", r[31:0], 32'h80000000);

    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_HI", bus.HI, 32'd0);
    check("reset_LO", bus.LO, 32'd0);

    run_op("mthi", MDU_MTHI, 32'hDEADBEEF, 32'd0, 0, 32'hDEADBEEF, 32'd0);
    run_op("mult", MDU_MULT, 32'hFFFFFFFD, 32'd5, 33, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h1);
    run_op("div", MDU_DIV, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);
    run_op("mthi2", MDU_MTHI, 32'hAAAA, 32'd0, 0, 32'hAAAA, 32'h80000000);
    run_op("mtlo", MDU_MTLO, 32'h5555, 32'd0, 0, 32'hAAAA, 32'h5555);
    run_op("divu_by0", MDU_DIVU, 32'h1234, 32'd0, 1, 32'hAAAA, 32'h5555);

    // MTLO issued while a MULT is in flight must be ignored.
    drive(MDU_MULT, 32'd7, 32'd9, 1'b0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.MDUctr = MDU_MTLO; bus.A = 32'h1111;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(n);
    check("mtlo_busy_HI", bus.HI, 32'h0);
    check("mtlo_busy_LO", bus.LO, 32'd63);

    // Flush a DIVU at counter=10: abort with no done and no write.
    drive(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    check("flush_done", {31'd0, bus.done}, 32'd0);
    check("flush_HI", bus.HI, 32'h0);
    check("flush_LO", bus.LO, 32'd63);

    // Flush together with start in IDLE drops even MTHI.
    drive(MDU_MTHI, 32'h55, 32'd0, 1'b1);
    check("flush_mthi_HI", bus.HI, 32'h0);
    check("flush_mthi_done", {31'd0, bus.done}, 32'd0);

    // Reset in the middle of a MULT, then a fresh request is accepted.
    drive(MDU_MULT, 32'd123, 32'd456, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_HI", bus.HI, 32'd0);
    check("midreset_LO", bus.LO, 32'd0);
    run_op("after_reset", MDU_MULTU, 32'd3, 32'd4, 33, 32'd0, 32'd12);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      drive(op, a, b, $urandom_range(0, 9) == 0);
      if (bus.busy && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 31)) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
      end else if (bus.busy && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        bus.start = 1'b1; bus.MDUctr = 3'($urandom_range(0, 5)); bus.A = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
      end
      wait_idle(n);
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Iterative multiply/divide unit with its own sequencer and the architectural HI/LO registers. It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO for the pipelined CPU.
- Sits beside the ALU in the EX stage. The hazard logic stalls IF/ID/EX while busy is high.
- Results are read from the HI and LO outputs, which feed the MFHI/MFLO path.

Parameters:
- WIDTH, 32, operand width. HI and LO are WIDTH each.
- ITER, WIDTH, number of shift/add or shift/subtract iterations per multiply or divide.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  EX-stage request; sampled only in IDLE.
- MDUctr  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x reserved, treated as no-op.
- A  in  WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO source).
- B  in  WIDTH  rt operand (multiplier or divisor).
- flush  in  1  exception/flush from the pipeline; aborts the operation in flight.
- busy  out  1  operation in progress; pipeline stall request.
- done  out  1  one-cycle pulse when new HI/LO values are visible.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
Reset (rst=0 at a clock edge):
- state=IDLE, HI=0, LO=0, busy=0, done=0, counter=0.
- Reset wins over every other input, including mid-operation.

States: IDLE, MUL, DIV, FIX.
- busy is 1 in MUL, DIV and FIX, and 0 in IDLE.

IDLE:
- start=1 with MTHI or MTLO: HI or LO takes A on that edge. Stay in IDLE, busy stays 0, done=1 the next cycle.
- start=1 with MULT/MULTU: latch operands → MUL.
  - Signed ops latch magnitudes |A| and |B| plus a negate flag (sign(A) XOR sign(B)).
  - Unsigned ops latch the raw values with negate flag = 0.
- start=1 with DIV/DIVU and B≠0: latch operands the same way → DIV.
  - Signed ops also record the dividend sign for the remainder.
- start=1 with DIV/DIVU and B=0: HI/LO unchanged. Go directly to FIX with a suppress flag set (busy=1 for exactly 1 cycle), then done pulse.
- Reserved codes and start=0: no effect.

MUL:
- Radix-2 shift-add on a 2×WIDTH product register, one iteration per cycle.
- counter runs 0..ITER-1. At counter=ITER-1 → FIX.

DIV:
- Restoring shift-subtract, one quotient bit per cycle.
- counter runs 0..ITER-1. At counter=ITER-1 → FIX.

FIX (1 cycle):
- Apply sign correction.
  - MULT: negate the full 64-bit product if the negate flag is set.
  - DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
- Write {HI,LO} = product, or HI=remainder / LO=quotient, on the FIX edge.
- → IDLE. done=1 in the following cycle.

Latency:
- MUL/DIV: busy high for exactly ITER+1 = 33 cycles, starting the cycle after start is sampled.
- done is asserted in the first IDLE cycle after FIX, coincident with the new HI/LO values.

Signed overflow:
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. No trap.

Concurrent and boundary events:
- start while busy: ignored. The pipeline must hold the instruction until busy=0.
- flush=1 in MUL/DIV/FIX: → IDLE next edge. HI/LO unchanged, no done pulse.
- flush=1 with start=1 in IDLE: the request is dropped, including MTHI/MTLO.
- Operand inputs are don't-care after the start edge.

Decomposition:
- Shared package holds:
  - MDU op-code constants (MDU_MULT … MDU_MTLO);
  - state encoding (IDLE, MUL, DIV, FIX);
  - ITER default.
- One natural sub-module, mdu_iter: the product/remainder shift register plus adder/subtractor, stepped by a shift-enable and a mode select.
- mdu_ctrl holds the FSM, counter, sign flags, sign fix-up and HI/LO.

Test Plan:
- Reset with rst=0 mid-MUL (counter=10) → next cycle: busy=0, HI=0, LO=0, state IDLE; a subsequent start is accepted normally.
- MULT A=0xFFFFFFFD (-3), B=5 → busy=1 for 33 cycles, done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 33 busy cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU A=0x1234, B=0 (HI/LO preloaded 0xAAAA/0x5555) → busy for 1 cycle, done pulse, HI/LO still 0xAAAA/0x5555.
- MTHI A=0xDEADBEEF while idle → HI=0xDEADBEEF next cycle, busy stays 0.
  - MTLO issued during MUL → ignored.
  - flush at counter=10 of a DIVU → busy=0 next cycle, no done, HI/LO unchanged.
